// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: op codes and default datapath width.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op == ALU_AND) || (op == ALU_OR)  || (op == ALU_ADD) ||
               (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_NOR);
    endfunction

endpackage

// File: rtl/alu_exec.sv
// Combinational integer ALU: one op per evaluation, zero flag taken from this result.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
);

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_NOR: result = ~(a | b);
            default: err = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a one-entry
// registered result stage under valid/ready backpressure.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_zero,
    output logic             resp_src,
    output logic             resp_err
);

    logic             last_q, last_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic             src_q, src_d;
    logic             err_q, err_d;

    logic             can_accept;
    logic             grant;
    logic             accept;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero, alu_err;

    // Readies depend only on valids, the output stage and reset, never on operands.
    assign can_accept = !valid_q || resp_ready;

    always_comb begin
        if (req0_valid && req1_valid) grant = !last_q;
        else if (req1_valid)          grant = 1'b1;
        else                          grant = 1'b0;
    end

    assign req0_ready = rst_n && can_accept && req0_valid && (grant == 1'b0);
    assign req1_ready = rst_n && can_accept && req1_valid && (grant == 1'b1);
    assign accept     = req0_ready || req1_ready;

    assign sel_op = grant ? req1_op : req0_op;
    assign sel_a  = grant ? req1_a  : req0_a;
    assign sel_b  = grant ? req1_b  : req0_b;

    alu_exec #(.WIDTH(WIDTH)) u_alu_exec (
        .op     (sel_op),
        .a      (sel_a),
        .b      (sel_b),
        .result (alu_result),
        .zero   (alu_zero),
        .err    (alu_err)
    );

    always_comb begin
        last_d  = last_q;
        valid_d = valid_q;
        data_d  = data_q;
        zero_d  = zero_q;
        src_d   = src_q;
        err_d   = err_q;
        if (accept) begin
            last_d  = grant;
            valid_d = 1'b1;
            data_d  = alu_result;
            zero_d  = alu_zero;
            src_d   = grant;
            err_d   = alu_err;
        end else if (resp_ready) begin
            valid_d = 1'b0;
        end
    end

    // last resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q  <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            src_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            last_q  <= last_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            src_q   <= src_d;
            err_q   <= err_d;
        end
    end

    assign resp_valid = valid_q;
    assign resp_data  = data_q;
    assign resp_zero  = zero_q;
    assign resp_src   = src_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with hand-computed expected values.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic        resp_zero, resp_src, resp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_zero  (resp_zero),
        .resp_src   (resp_src),
        .resp_err   (resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_resp(input string tag, input logic v, input logic [31:0] d,
                            input logic z, input logic s, input logic e);
        chk({tag, ".valid"}, {31'd0, resp_valid}, {31'd0, v});
        chk({tag, ".data"},  resp_data, d);
        chk({tag, ".zero"},  {31'd0, resp_zero}, {31'd0, z});
        chk({tag, ".src"},   {31'd0, resp_src}, {31'd0, s});
        chk({tag, ".err"},   {31'd0, resp_err}, {31'd0, e});
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        chk({tag, ".rdy0"}, {31'd0, req0_ready}, {31'd0, r0});
        chk({tag, ".rdy1"}, {31'd0, req1_ready}, {31'd0, r1});
    endtask

    task automatic set0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic set1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    endtask

    initial begin
        // Reset held two cycles with both requesters pending
        rst_n = 1'b0; resp_ready = 1'b1;
        set0(1'b1, 4'b0010, 32'd1, 32'd1);
        set1(1'b1, 4'b0010, 32'd2, 32'd2);
        step();
        chk_rdy("rst1", 1'b0, 1'b0);
        step();
        chk_resp("rst2", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk_rdy("rst2", 1'b0, 1'b0);

        // Release with only req0 ADD 5+7
        rst_n = 1'b1;
        set0(1'b1, 4'b0010, 32'd5, 32'd7);
        set1(1'b0, 4'b0001, 32'd0, 32'd0);
        #1;
        chk_rdy("add", 1'b1, 1'b0);
        step();
        chk_resp("add", 1'b1, 32'd12, 1'b0, 1'b0, 1'b0);

        // Contention: last=0 after the ADD, so grants go 1,0,1,0
        set0(1'b1, 4'b0110, 32'd3, 32'd3);
        set1(1'b1, 4'b0001, 32'h0000_00F0, 32'h0000_000F);
        #1;
        chk_rdy("cont1", 1'b0, 1'b1);
        step();
        chk_resp("cont1", 1'b1, 32'h0000_00FF, 1'b0, 1'b1, 1'b0);
        chk_rdy("cont2", 1'b1, 1'b0);
        step();
        chk_resp("cont2", 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
        chk_rdy("cont3", 1'b0, 1'b1);
        step();
        chk_resp("cont3", 1'b1, 32'h0000_00FF, 1'b0, 1'b1, 1'b0);
        chk_rdy("cont4", 1'b1, 1'b0);
        step();
        chk_resp("cont4", 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);

        // Backpressure: req1 NOR 0|0, then stall three cycles with req0 pending
        set0(1'b0, 4'b0010, 32'd1, 32'd1);
        set1(1'b1, 4'b1100, 32'd0, 32'd0);
        #1;
        chk_rdy("nor", 1'b0, 1'b1);
        step();
        chk_resp("nor", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        resp_ready = 1'b0;
        set0(1'b1, 4'b0010, 32'd1, 32'd1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_rdy("stall", 1'b0, 1'b0);
            step();
            chk_resp("stall", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        end
        // Release: drain and accept in the same cycle, req0 wins since last=1
        resp_ready = 1'b1;
        #1;
        chk_rdy("release", 1'b1, 1'b0);
        step();
        chk_resp("release", 1'b1, 32'd2, 1'b0, 1'b0, 1'b0);

        // SLT and wrap vectors on req0 alone
        set1(1'b0, 4'b0000, 32'd0, 32'd0);
        set0(1'b1, 4'b0111, 32'd1, 32'd2);
        step();
        chk_resp("slt_lt", 1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
        set0(1'b1, 4'b0111, 32'hFFFF_FFFF, 32'd1);
        step();
        chk_resp("slt_uns", 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
        set0(1'b1, 4'b0010, 32'hFFFF_FFFF, 32'd1);
        step();
        chk_resp("add_wrap", 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
        set0(1'b1, 4'b0110, 32'd0, 32'd1);
        step();
        chk_resp("sub_wrap", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        set0(1'b1, 4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
        step();
        chk_resp("and", 1'b1, 32'h0000_F000, 1'b0, 1'b0, 1'b0);

        // Illegal op, then a legal op clears err
        set0(1'b1, 4'b0011, 32'h1234_5678, 32'h1111_1111);
        step();
        chk_resp("illegal", 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
        set0(1'b1, 4'b0001, 32'h0000_0A00, 32'h0000_0005);
        step();
        chk_resp("legal", 1'b1, 32'h0000_0A05, 1'b0, 1'b0, 1'b0);

        // Drain without accept: valid clears, data holds
        set0(1'b0, 4'b0001, 32'd0, 32'd0);
        step();
        chk_resp("drain", 1'b0, 32'h0000_0A05, 1'b0, 1'b0, 1'b0);

        // Reset mid-operation while stalled; last is 0 going in
        set0(1'b1, 4'b0010, 32'd10, 32'd20);
        step();
        chk_resp("pre_rst", 1'b1, 32'd30, 1'b0, 1'b0, 1'b0);
        resp_ready = 1'b0;
        set1(1'b1, 4'b0001, 32'd1, 32'd2);
        step();
        rst_n = 1'b0;
        resp_ready = 1'b1;
        #1;
        chk_rdy("in_rst", 1'b0, 1'b0);
        step();
        chk_resp("post_rst", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        set0(1'b1, 4'b0110, 32'd9, 32'd4);
        #1;
        chk_rdy("rst_ptr", 1'b1, 1'b0);
        step();
        chk_resp("rst_ptr", 1'b1, 32'd5, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
